// File: rtl/fetch_prefetch_unit_if.sv
// Fetch front-end bus bundle: instruction memory request/response
// plus the show-ahead queue head toward IF/ID.
interface fetch_prefetch_unit_if #(
    parameter int DEPTH = 4
);
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [31:0]              imem_req_addr;
    logic                     imem_rsp_valid;
    logic [31:0]              imem_rsp_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_pc;
    logic [31:0]              out_instr;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output out_valid, out_pc, out_instr, count,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  out_valid, out_pc, out_instr, count,
        output out_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: credit-limited word fetch, in-order
// response capture into a show-ahead prefetch queue, redirect flush.
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    fetch_prefetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    cnt_t          outstanding;
    cnt_t          discard;
    cnt_t          cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];

    logic [CW:0]   credits_used;
    logic          req_fire;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [31:0]   target;
    logic          unused_pc_lsb;

    // Queued words plus in-flight fetches may never exceed DEPTH.
    assign credits_used = {1'b0, cnt} + {1'b0, outstanding};
    assign bus.imem_req_valid = rst_n & ~redirect & (credits_used < LIMIT);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire = bus.imem_req_valid & bus.imem_req_ready;

    assign rsp_drop   = (discard != '0);
    assign head_valid = (cnt != '0);
    assign push = bus.imem_rsp_valid & ~rsp_drop & ~redirect;
    assign pop  = head_valid & bus.out_ready & ~redirect;

    assign target        = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign bus.out_valid = rst_n & head_valid;
    assign bus.out_pc    = q_pc[rd_ptr];
    assign bus.out_instr = q_instr[rd_ptr];
    assign bus.count     = rst_n ? cnt : '0;

    // PC, credit, discard and queue pointer state; redirect wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect) begin
            fetch_pc    <= target;
            rsp_pc      <= target;
            outstanding <= outstanding - cnt_t'(bus.imem_rsp_valid);
            discard     <= outstanding - cnt_t'(bus.imem_rsp_valid);
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + cnt_t'(req_fire)
                         - cnt_t'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid && rsp_drop) begin
                discard <= discard - 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // Queue storage: captured words with their PCs, no reset needed.
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            q_pc[wr_ptr]    <= rsp_pc;
            q_instr[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: variable-latency memory model,
// epoch-tagged fetch scoreboard and directed/random scenarios.
module tb_fetch_prefetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_prefetch_unit_if #(.DEPTH(DEPTH)) bus ();

    fetch_prefetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } fly_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    fly_t        fly[$];
    ent_t        mq[$];
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          rand_lat = 0;
    logic [31:0] exp_req = RESET_PC;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9E17;
    endfunction

    // Memory: returns the oldest fetch once its latency elapsed.
    always @(negedge clk) begin
        if (fly.size() != 0 && fly[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(fly[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    // Reference: every fetch is tagged with the epoch it was issued in;
    // only current-epoch words outside a redirect cycle reach the queue.
    always @(posedge clk) begin
        fly_t f;
        ent_t e;
        if (!rst_n) begin
            fly.delete();
            mq.delete();
            epoch++;
            exp_req = RESET_PC;
        end else begin
            if (bus.out_valid && bus.out_ready && !redirect
                && mq.size() != 0) begin
                void'(mq.pop_front());
            end
            if (bus.imem_rsp_valid && fly.size() != 0) begin
                f = fly.pop_front();
                if (!redirect && f.epoch == epoch) begin
                    e.pc    = f.addr;
                    e.instr = mem_word(f.addr);
                    mq.push_back(e);
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                f.addr  = bus.imem_req_addr;
                f.epoch = epoch;
                f.due   = cyc + (rand_lat ? int'($urandom_range(4, 1)) : lat);
                fly.push_back(f);
                exp_req = exp_req + 32'd4;
            end
            if (redirect) begin
                epoch++;
                mq.delete();
                exp_req = {redirect_pc[31:2], 2'b00};
            end
        end
        cyc++;
    end

    // Per-cycle protocol checks against the reference.
    always begin
        logic       exp_rv;
        int         exp_cnt;
        @(negedge clk);
        #3;
        exp_rv  = rst_n && !redirect && (mq.size() + fly.size() < DEPTH);
        exp_cnt = rst_n ? mq.size() : 0;
        n_cmp++;
        if (bus.imem_req_valid !== exp_rv) begin
            n_bad++;
            $display("FAIL mon_req_valid cyc=%0d got=%b exp=%b",
                     cyc, bus.imem_req_valid, exp_rv);
        end
        if (exp_rv && bus.imem_req_valid) begin
            n_cmp++;
            if (bus.imem_req_addr !== exp_req) begin
                n_bad++;
                $display("FAIL mon_req_addr cyc=%0d got=%h exp=%h",
                         cyc, bus.imem_req_addr, exp_req);
            end
        end
        n_cmp++;
        if (bus.count !== ($clog2(DEPTH)+1)'(exp_cnt)) begin
            n_bad++;
            $display("FAIL mon_count cyc=%0d got=%0d exp=%0d",
                     cyc, bus.count, exp_cnt);
        end
        n_cmp++;
        if (bus.out_valid !== (exp_cnt != 0)) begin
            n_bad++;
            $display("FAIL mon_out_valid cyc=%0d got=%b exp=%b",
                     cyc, bus.out_valid, exp_cnt != 0);
        end
        if (rst_n && mq.size() != 0) begin
            n_cmp++;
            if (bus.out_pc !== mq[0].pc || bus.out_instr !== mq[0].instr) begin
                n_bad++;
                $display("FAIL mon_head cyc=%0d got=%h/%h exp=%h/%h", cyc,
                         bus.out_pc, bus.out_instr, mq[0].pc, mq[0].instr);
            end
        end
        n_cmp++;
        if (mq.size() + fly.size() > DEPTH) begin
            n_bad++;
            $display("FAIL mon_overflow cyc=%0d got=%0d exp<=%0d",
                     cyc, mq.size() + fly.size(), DEPTH);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.out_ready = 1'b0;
        rand_lat = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #3;
        n_cmp++;
        if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0
            || bus.count !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b/%b/%0d exp=0/0/0",
                     bus.imem_req_valid, bus.out_valid, bus.count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        n_cmp++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL reset_first_req got=%b/%h exp=1/%h",
                     bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int          first_fire = -1;
        int          first_val = -1;
        logic [31:0] fa[$];
        logic [31:0] pp[$];
        logic [31:0] pi[$];
        do_reset();
        lat = 1;
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                if (first_fire < 0) first_fire = k;
                if (fa.size() < 3) fa.push_back(bus.imem_req_addr);
            end
            if (bus.out_valid) begin
                if (first_val < 0) first_val = k;
                if (pp.size() < 3) begin
                    pp.push_back(bus.out_pc);
                    pi.push_back(bus.out_instr);
                end
            end
        end
        n_cmp++;
        if (first_val - first_fire !== 2) begin
            n_bad++;
            $display("FAIL stream_latency got=%0d exp=2", first_val - first_fire);
        end
        n_cmp++;
        if (fa.size() != 3 || pp.size() != 3) begin
            n_bad++;
            $display("FAIL stream_count got=%0d/%0d exp=3/3", fa.size(), pp.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (fa[i] !== RESET_PC + 32'(4*i) || pp[i] !== RESET_PC + 32'(4*i)
                    || pi[i] !== mem_word(RESET_PC + 32'(4*i))) begin
                    n_bad++;
                    $display("FAIL stream_seq%0d got=%h/%h/%h exp=%h/%h/%h", i,
                             fa[i], pp[i], pi[i], RESET_PC + 32'(4*i),
                             RESET_PC + 32'(4*i), mem_word(RESET_PC + 32'(4*i)));
                end
            end
        end
    endtask

    task automatic test_credit();
        int fires = 0;
        do_reset();
        lat = 1;
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            if (bus.imem_req_valid && bus.imem_req_ready) fires++;
        end
        n_cmp++;
        if (fires !== DEPTH || bus.imem_req_valid !== 1'b0
            || bus.count !== 3'(DEPTH)) begin
            n_bad++;
            $display("FAIL credit_fill got=%0d/%b/%0d exp=%0d/0/%0d",
                     fires, bus.imem_req_valid, bus.count, DEPTH, DEPTH);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        fires = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            if (bus.imem_req_valid && bus.imem_req_ready) fires++;
        end
        n_cmp++;
        if (fires !== 1 || bus.count !== 3'(DEPTH)) begin
            n_bad++;
            $display("FAIL credit_refill got=%0d/%0d exp=1/%0d",
                     fires, bus.count, DEPTH);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] pp[$];
        do_reset();
        lat = 3;
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        #3;
        n_cmp++;
        if (bus.imem_req_valid !== 1'b0 || fly.size() != 2) begin
            n_bad++;
            $display("FAIL redir_setup got=%b/%0d exp=0/2",
                     bus.imem_req_valid, fly.size());
        end
        @(negedge clk);
        redirect = 1'b0;
        bus.imem_req_ready = 1'b1;
        #3;
        n_cmp++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_flush got=%0d/%b exp=0/0",
                     bus.count, bus.out_valid);
        end
        for (int k = 0; k < 30 && pp.size() < 2; k++) begin
            @(negedge clk);
            #3;
            if (bus.out_valid && bus.out_ready) pp.push_back(bus.out_pc);
        end
        n_cmp++;
        if (pp.size() != 2 || pp[0] !== 32'h100 || pp[1] !== 32'h104) begin
            n_bad++;
            $display("FAIL redir_target got=%0d pcs exp=0x100,0x104", pp.size());
        end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] pp[$];
        bit          stale = 1'b0;
        do_reset();
        lat = 1;
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0400;
        #3;
        n_cmp++;
        if (bus.imem_rsp_valid !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL collide_setup got=%b/%b exp=1/1",
                     bus.imem_rsp_valid, bus.out_valid);
        end
        @(negedge clk);
        redirect = 1'b0;
        #3;
        n_cmp++;
        if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_flush got=%0d/%b exp=0/0",
                     bus.count, bus.out_valid);
        end
        for (int k = 0; k < 20 && pp.size() < 3; k++) begin
            @(negedge clk);
            #3;
            if (bus.out_valid && bus.out_ready) begin
                if (bus.out_pc !== 32'h400 + 32'(4*pp.size())) stale = 1'b1;
                pp.push_back(bus.out_pc);
            end
        end
        n_cmp++;
        if (pp.size() != 3 || stale) begin
            n_bad++;
            $display("FAIL collide_stream got=%0d/%b exp=3/0", pp.size(), stale);
        end
    endtask

    task automatic test_misaligned();
        bit got = 1'b0;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        @(negedge clk);
        redirect = 1'b0;
        #3;
        n_cmp++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
            n_bad++;
            $display("FAIL misalign_req got=%b/%h exp=1/00000200",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            #3;
            if (bus.out_valid && bus.out_ready) begin
                got = 1'b1;
                n_cmp++;
                if (bus.out_pc !== 32'h200 || bus.out_instr !== mem_word(32'h200)) begin
                    n_bad++;
                    $display("FAIL misalign_out got=%h/%h exp=00000200/%h",
                             bus.out_pc, bus.out_instr, mem_word(32'h200));
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL misalign_timeout got=0 exp=1");
        end
    endtask

    task automatic test_midreset();
        bit found = 1'b0;
        bit got = 1'b0;
        do_reset();
        lat = 1;
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.count == 3) found = 1'b1;
        end
        n_cmp++;
        if (!found || bus.imem_req_valid !== 1'b0 || fly.size() != 1) begin
            n_bad++;
            $display("FAIL midrst_setup got=%b/%b/%0d exp=1/0/1",
                     found, bus.imem_req_valid, fly.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #3;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.count !== '0
            || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL midrst_state got=%b/%0d/%b/%h exp=0/0/1/%h",
                     bus.out_valid, bus.count, bus.imem_req_valid,
                     bus.imem_req_addr, RESET_PC);
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            #3;
            if (bus.out_valid && bus.out_ready) begin
                got = 1'b1;
                n_cmp++;
                if (bus.out_pc !== RESET_PC) begin
                    n_bad++;
                    $display("FAIL midrst_pc got=%h exp=%h", bus.out_pc, RESET_PC);
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL midrst_timeout got=0 exp=1");
        end
    endtask

    task automatic test_random();
        int pops = 0;
        do_reset();
        rand_lat = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst_n = ($urandom_range(499, 0) != 0);
            bus.imem_req_ready = ($urandom_range(3, 0) != 0);
            bus.out_ready = ($urandom_range(2, 0) != 0);
            redirect = ($urandom_range(19, 0) == 0);
            redirect_pc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF6 : $urandom;
            #3;
            if (rst_n && !redirect && bus.out_valid && bus.out_ready) pops++;
        end
        n_cmp++;
        if (pops < 100) begin
            n_bad++;
            $display("FAIL random_pops got=%0d exp>=100", pops);
        end
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_credit();
        test_redirect();
        test_redirect_collide();
        test_misaligned();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
